mc_compound_acc: RTL and testbench

Multi-channel successor to the single-port compound-message section block. It polls CHANNELS blocking compound-type input ports round-robin and keeps one DATA_WIDTH accumulator per channel. WRITE messages update the channel's accumulator; READ messages return accumulator + x on a shared master output tagged with the channel index. It sits between message producers and a downstream consumer using the codebase's sync/notify handshake.

---
 rtl/mc_compound_acc_pkg.sv | 11 +
 rtl/mc_compound_acc_if.sv | 17 +
 rtl/mc_acc_bank.sv | 28 ++
 rtl/mc_compound_acc.sv | 79 +++++++
 tb/tb_mc_compound_acc.sv | 117 +++++++++++
 5 files changed

// File: rtl/mc_compound_acc_pkg.sv
// mc_compound_acc_types: shared enums, message field offsets and width helper
package mc_compound_acc_types;
  typedef enum logic {READ, WRITE} mode_t;
  typedef enum logic [1:0] {SECTION_IDLE, SECTION_EXEC, SECTION_EMIT} sections_t;
  typedef enum logic [1:0] {ACC_NOP, ACC_ADD, ACC_LOAD, ACC_CLEAR} acc_op_t;
  localparam int MSG_Y_BIT = 0;
  localparam int MSG_X_LSB = 1;
  function automatic int chan_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mc_compound_acc_if.sv
// mc_compound_acc_if: producer-side sync/notify ports and the tagged result output
interface mc_compound_acc_if
  import mc_compound_acc_types::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = chan_w(CHANNELS);
  logic [CHANNELS*(DATA_WIDTH+2)-1:0] b_in;
  logic [CHANNELS-1:0]                b_in_sync;
  logic [CHANNELS-1:0]                b_in_notify;
  logic [DATA_WIDTH-1:0]              m_out;
  logic [CW-1:0]                      m_out_chan;
  logic                               m_out_notify;
  modport master (output b_in, b_in_sync, input b_in_notify, m_out, m_out_chan, m_out_notify);
  modport slave  (input b_in, b_in_sync, output b_in_notify, m_out, m_out_chan, m_out_notify);
endinterface

// File: rtl/mc_acc_bank.sv
// mc_acc_bank: per-channel accumulators with one add/load/clear port; SATURATE_EN clamps the adder
module mc_acc_bank
  import mc_compound_acc_types::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  acc_op_t               op,
  input  logic [CW-1:0]         idx,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] sum
);
  logic [DATA_WIDTH-1:0] acc [CHANNELS];
  logic [DATA_WIDTH:0]   raw;
  assign raw = {1'b0, acc[idx]} + {1'b0, operand};
`ifdef SATURATE_EN
  assign sum = raw[DATA_WIDTH] ? '1 : raw[DATA_WIDTH-1:0];
`else
  assign sum = raw[DATA_WIDTH-1:0];
`endif
  // accumulator storage: cleared by reset, otherwise one channel updated per op
  always_ff @(posedge clk)
    if (!rst) for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    else if (op != ACC_NOP) acc[idx] <= op == ACC_ADD ? sum : op == ACC_LOAD ? operand : '0;
endmodule

// File: rtl/mc_compound_acc.sv
// mc_compound_acc: round-robin compound-message accumulator; optional SATURATE_EN clamps sums
module mc_compound_acc
  import mc_compound_acc_types::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  mc_compound_acc_if.slave bus
);
  localparam int CW = chan_w(CHANNELS);
  localparam int MW = DATA_WIDTH + 2;
  localparam logic [CHANNELS-1:0] ONE = 1;
  sections_t             section, section_nxt;
  logic [CW-1:0]         ptr, ptr_nxt, chan;
  logic [MW-1:0]         msg;
  logic [DATA_WIDTH-1:0] x, sum, m_out;
  logic [CW-1:0]         m_out_chan;
  logic [CHANNELS-1:0]   notify;
  logic                  y, m_out_notify, transfer;
  mode_t                 mode;
  acc_op_t               op;
  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] p);
    return int'(p) == CHANNELS - 1 ? '0 : p + 1'b1;
  endfunction
  assign x        = msg[MSG_X_LSB +: DATA_WIDTH];
  assign y        = msg[MSG_Y_BIT];
  assign mode     = mode_t'(msg[MW-1]);
  assign transfer = section == SECTION_IDLE && notify[ptr] && bus.b_in_sync[ptr];
  assign bus.b_in_notify  = notify;
  assign bus.m_out        = m_out;
  assign bus.m_out_chan   = m_out_chan;
  assign bus.m_out_notify = m_out_notify;
  mc_acc_bank #(.CHANNELS(CHANNELS), .DATA_WIDTH(DATA_WIDTH), .CW(CW)) u_bank (
    .clk(clk), .rst(rst), .op(op), .idx(chan), .operand(x), .sum(sum)
  );
  // section and poll pointer registers
  always_ff @(posedge clk)
    if (!rst) begin
      section <= SECTION_IDLE;
      ptr     <= '0;
    end else begin
      section <= section_nxt;
      ptr     <= ptr_nxt;
    end
  // next section; the pointer resumes after the served channel so nobody is granted twice in a row
  always_comb begin
    section_nxt = section == SECTION_IDLE ? (transfer ? SECTION_EXEC : SECTION_IDLE) :
                  section == SECTION_EXEC ? (mode == READ ? SECTION_EMIT : SECTION_IDLE) : SECTION_IDLE;
    ptr_nxt     = section == SECTION_IDLE ? (transfer ? ptr : wrap_inc(ptr)) :
                  section_nxt == SECTION_IDLE ? wrap_inc(chan) : ptr;
  end
  // accumulator operation issued while executing a latched message
  always_comb
    op = section != SECTION_EXEC ? ACC_NOP :
         mode == WRITE ? (y ? ACC_LOAD : ACC_ADD) : (y ? ACC_CLEAR : ACC_NOP);
  // message latch, registered notify and result outputs
  always_ff @(posedge clk)
    if (!rst) begin
      msg          <= '0;
      chan         <= '0;
      notify       <= ONE;
      m_out        <= '0;
      m_out_chan   <= '0;
      m_out_notify <= 1'b0;
    end else begin
      if (transfer) begin
        msg  <= bus.b_in[int'(ptr)*MW +: MW];
        chan <= ptr;
      end
      notify       <= section_nxt == SECTION_IDLE ? ONE << ptr_nxt : '0;
      m_out_notify <= section == SECTION_EXEC && mode == READ;
      if (section == SECTION_EXEC && mode == READ) begin
        m_out      <= sum;
        m_out_chan <= chan;
      end
    end
endmodule

// File: tb/tb_mc_compound_acc.sv
// tb_mc_compound_acc: directed checks of polling, accumulate/read timing, wrap/saturate and reset
module tb_mc_compound_acc;
  import mc_compound_acc_types::*;
  localparam int CH = 4;
  localparam int DW = 32;
  localparam int MW = DW + 2;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int order [2];
  int got, g;
  mc_compound_acc_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) bus ();
  mc_compound_acc #(.CHANNELS(CH), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int ch, input mode_t mode, input logic [DW-1:0] x, input logic y);
    bus.b_in[ch*MW +: MW] = {mode, x, y};
    bus.b_in_sync[ch] = 1'b1;
  endtask
  task automatic wait_grant(input int ch);
    for (int n = 0; n < 3*CH + 4 && !bus.b_in_notify[ch]; n++) tick;
    check($sformatf("grant_ch%0d", ch), {63'd0, bus.b_in_notify[ch]}, 64'd1);
    tick;
    bus.b_in_sync[ch] = 1'b0;
  endtask
  task automatic xfer(input string tag, input int ch, input mode_t mode, input logic [DW-1:0] x,
                      input logic y, input logic [DW-1:0] exp);
    logic [CH-1:0] oh;
    oh = 1;
    oh = oh << ((ch + 1) % CH);
    load(ch, mode, x, y);
    wait_grant(ch);
    check({tag, "_exec_notify"}, {60'd0, bus.b_in_notify}, 64'd0);
    check({tag, "_exec_pulse"}, {63'd0, bus.m_out_notify}, 64'd0);
    tick;
    if (mode == READ) begin
      check({tag, "_pulse"}, {63'd0, bus.m_out_notify}, 64'd1);
      check({tag, "_m_out"}, {32'd0, bus.m_out}, {32'd0, exp});
      check({tag, "_chan"}, {62'd0, bus.m_out_chan}, 64'(ch));
      tick;
      check({tag, "_pulse_end"}, {63'd0, bus.m_out_notify}, 64'd0);
    end
    check({tag, "_next_poll"}, {60'd0, bus.b_in_notify}, {60'd0, oh});
  endtask
  initial begin
    bus.b_in = '0;
    bus.b_in_sync = '0;
    tick;
    tick;
    check("rst_notify", {60'd0, bus.b_in_notify}, 64'd1);
    check("rst_m_out", {32'd0, bus.m_out}, 64'd0);
    check("rst_pulse", {63'd0, bus.m_out_notify}, 64'd0);
    check("rst_chan", {62'd0, bus.m_out_chan}, 64'd0);
    load(1, WRITE, 32'd7, 1'b1);
    load(3, WRITE, 32'd9, 1'b1);
    rst = 1'b1;
    got = 0;
    order = '{-1, -1};
    for (int n = 0; n < 20 && got < 2; n++) begin
      g = -1;
      for (int c = 0; c < CH; c++) if (bus.b_in_notify[c] && bus.b_in_sync[c]) g = c;
      tick;
      if (g >= 0) begin
        bus.b_in_sync[g] = 1'b0;
        order[got] = g;
        got++;
      end
    end
    check("arb_first", 64'(order[0]), 64'd1);
    check("arb_second", 64'(order[1]), 64'd3);
    xfer("arb_rd1", 1, READ, 32'd0, 1'b0, 32'd7);
    xfer("arb_rd3", 3, READ, 32'd0, 1'b0, 32'd9);
    xfer("rst_acc0", 0, READ, 32'd0, 1'b0, 32'd0);
    xfer("rst_acc2", 2, READ, 32'd0, 1'b0, 32'd0);
    xfer("c2_wr", 2, WRITE, 32'd5, 1'b0, 32'd0);
    xfer("c2_rd", 2, READ, 32'd3, 1'b0, 32'd8);
    xfer("c0_ld", 0, WRITE, 32'd10, 1'b1, 32'd0);
    xfer("c0_rdclr", 0, READ, 32'd0, 1'b1, 32'd10);
    xfer("c0_rd0", 0, READ, 32'd0, 1'b0, 32'd0);
    xfer("c1_ldmax", 1, WRITE, 32'hFFFF_FFFF, 1'b1, 32'd0);
    xfer("c1_rdovf", 1, READ, 32'd1, 1'b0, SAT ? 32'hFFFF_FFFF : 32'd0);
    xfer("c1_addovf", 1, WRITE, 32'd2, 1'b0, 32'd0);
    xfer("c1_rdacc", 1, READ, 32'd0, 1'b0, SAT ? 32'hFFFF_FFFF : 32'd1);
    xfer("c2_ld", 2, WRITE, 32'd4, 1'b1, 32'd0);
    load(2, READ, 32'd0, 1'b0);
    wait_grant(2);
    rst = 1'b0;
    tick;
    check("mid_rst_pulse", {63'd0, bus.m_out_notify}, 64'd0);
    check("mid_rst_notify", {60'd0, bus.b_in_notify}, 64'd1);
    check("mid_rst_m_out", {32'd0, bus.m_out}, 64'd0);
    check("mid_rst_chan", {62'd0, bus.m_out_chan}, 64'd0);
    tick;
    check("mid_rst_pulse2", {63'd0, bus.m_out_notify}, 64'd0);
    rst = 1'b1;
    xfer("post_rst_c2", 2, READ, 32'd0, 1'b0, 32'd0);
    xfer("post_rst_c1", 1, READ, 32'd0, 1'b0, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
